// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared defaults, stage-count helper and per-stage control entry
package pipelined_adder_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_SEG_WIDTH = 4;
   function automatic int calc_stages(input int width, input int seg_width);
      return (seg_width < 1) ? 1 : width / seg_width;
   endfunction
   typedef struct packed {
      logic valid;
      logic carry;
      logic sub;
   } stage_t;
endpackage

// File: rtl/pipelined_adder_ripple_segment.sv
// ripple_segment: combinational SEG_WIDTH-bit ripple adder; co_msb_in is the carry into its top bit
module ripple_segment #(
   parameter int SEG_WIDTH = 4
) (
   input  logic [SEG_WIDTH-1:0] a,
   input  logic [SEG_WIDTH-1:0] b,
   input  logic                 ci,
   output logic [SEG_WIDTH-1:0] s,
   output logic                 co,
   output logic                 co_msb_in
);
   logic [SEG_WIDTH:0] c;
   always_comb begin
      c[0] = ci;
      s = '0;
      for (int i = 0; i < SEG_WIDTH; i++) begin
         s[i] = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end
   assign co = c[SEG_WIDTH];
   assign co_msb_in = c[SEG_WIDTH-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: segmented ripple-carry add/sub, one segment per stage, valid/ready with global stall.
// Defining PIPELINED_ADDER_FLAGS_EN adds aligned ovf/zero outputs.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEG_WIDTH = DEF_SEG_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             cout
`ifdef PIPELINED_ADDER_FLAGS_EN
   ,
   output logic             ovf,
   output logic             zero
`endif
);
   localparam int STAGES = calc_stages(WIDTH, SEG_WIDTH);
   logic adv;
   assign adv = !out_valid || out_ready;
   assign in_ready = adv;
   if (SEG_WIDTH < 1) begin : g_bad_seg
      $error("pipelined_adder: SEG_WIDTH must be at least 1");
   end else if (WIDTH % SEG_WIDTH != 0) begin : g_bad_width
      $error("pipelined_adder: WIDTH must be a multiple of SEG_WIDTH");
   end
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      // IW: operand bits not yet added on entry to this stage; LO: result bits held after it
      localparam int IW = WIDTH - k * SEG_WIDTH;
      localparam int LO = (k + 1) * SEG_WIDTH;
      logic [IW-1:0] a_i;
      logic [IW-1:0] b_i;
      logic ci;
      logic vi;
      logic sb;
      logic co;
      logic [SEG_WIDTH-1:0] s_seg;
      logic [LO-1:0] s_nx;
      logic [LO-1:0] s_lo;
      stage_t st;
      if (k == 0) begin : g_src
         assign a_i = A;
         assign b_i = sub ? ~B : B;
         assign ci = sub | cin;
         assign vi = in_valid;
         assign sb = sub;
         assign s_nx = s_seg;
      end else begin : g_src
         assign a_i = g_st[k-1].g_skew.a_hi;
         assign b_i = g_st[k-1].g_skew.b_hi;
         assign ci = g_st[k-1].st.carry;
         assign vi = g_st[k-1].st.valid;
         assign sb = g_st[k-1].st.sub;
         assign s_nx = {s_seg, g_st[k-1].s_lo};
      end
`ifdef PIPELINED_ADDER_FLAGS_EN
      logic cm;
      ripple_segment #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
         .a(a_i[SEG_WIDTH-1:0]), .b(b_i[SEG_WIDTH-1:0]), .ci(ci),
         .s(s_seg), .co(co), .co_msb_in(cm)
      );
`else
      ripple_segment #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
         .a(a_i[SEG_WIDTH-1:0]), .b(b_i[SEG_WIDTH-1:0]), .ci(ci),
         .s(s_seg), .co(co), .co_msb_in()
      );
`endif
      always_ff @(posedge clk)
         if (rst) begin
            st <= '0;
            s_lo <= '0;
         end else if (adv) begin
            st <= '{valid: vi, carry: co, sub: sb};
            s_lo <= s_nx;
         end
      if (k < STAGES - 1) begin : g_skew
         logic [IW-SEG_WIDTH-1:0] a_hi;
         logic [IW-SEG_WIDTH-1:0] b_hi;
         always_ff @(posedge clk)
            if (adv) begin
               a_hi <= a_i[IW-1:SEG_WIDTH];
               b_hi <= b_i[IW-1:SEG_WIDTH];
            end
      end
   end
   assign out_valid = g_st[STAGES-1].st.valid;
   assign cout = g_st[STAGES-1].st.carry;
   assign S = g_st[STAGES-1].s_lo;
`ifdef PIPELINED_ADDER_FLAGS_EN
   always_ff @(posedge clk)
      if (rst) begin
         ovf <= 1'b0;
         zero <= 1'b0;
      end else if (adv) begin
         ovf <= g_st[STAGES-1].co ^ g_st[STAGES-1].cm;
         zero <= ~|g_st[STAGES-1].s_nx;
      end
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks of latency, add/sub, streaming, stall and mid-run reset.
module tb_pipelined_adder;
   logic clk, rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
   logic [15:0] A, B, S;
`ifdef PIPELINED_ADDER_FLAGS_EN
   logic ovf, zero;
`endif
   int errors = 0;
   int checks = 0;

   logic [15:0] va[8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F, 16'h1000, 16'h0000, 16'hABCD, 16'hABCD};
   logic [15:0] vb[8] = '{16'h1111, 16'hFFFF, 16'h8000, 16'h00F1, 16'h0001, 16'h0001, 16'h1234, 16'hABCD};
   logic vc[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic vs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [16:0] ve[8] = '{17'h02345, 17'h1FFFF, 17'h10000, 17'h01000, 17'h10FFF, 17'h0FFFF, 17'h0BE02, 17'h10000};

   pipelined_adder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .S(S), .cout(cout)
`ifdef PIPELINED_ADDER_FLAGS_EN
      , .ovf(ovf), .zero(zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; cin = 1'b0; sub = 1'b0;
      step(); step();
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (S !== 16'h0000) begin errors++; $display("FAIL reset_S: got %h expected 0000", S); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef PIPELINED_ADDER_FLAGS_EN
      checks++; if ({ovf, zero} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", ovf, zero); end
`endif
      step();
   endtask

   task automatic run_one(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s, input logic [16:0] e,
                          input logic eo, input logic ez);
      int lat;
      A = a; B = b; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
      step();
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      checks++; if (lat != 4) begin errors++; $display("FAIL %s_latency: got %0d expected 4", name, lat); end
      checks++; if ({cout, S} !== e) begin errors++; $display("FAIL %s_result: got %h expected %h", name, {cout, S}, e); end
`ifdef PIPELINED_ADDER_FLAGS_EN
      checks++; if ({ovf, zero} !== {eo, ez}) begin errors++; $display("FAIL %s_flags: got ovf,zero=%b%b expected %b%b", name, ovf, zero, eo, ez); end
`else
      if (eo === 1'bx || ez === 1'bx) $display("note: undefined flag expectation for %s", name);
`endif
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: got out_valid=%b expected 0", name, out_valid); end
   endtask

   task automatic test_add_sub();
      run_one("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0, 1'b1);
      run_one("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0FFFE, 1'b0, 1'b0);
      run_one("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002, 1'b0, 1'b0);
   endtask

   task automatic test_flags();
      run_one("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1, 1'b0);
      run_one("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, 1'b1, 1'b1);
      run_one("sub_zero", 16'h0003, 16'h0003, 1'b0, 1'b1, 17'h10000, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      int i = 0, r = 0, cyc = 0, first = -1, last = -1;
      out_ready = 1'b1;
      while (r < 8 && cyc < 40) begin
         in_valid = (i < 8);
         if (i < 8) begin A = va[i]; B = vb[i]; cin = vc[i]; sub = vs[i]; end
         #1;
         if (i < 8) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1 at beat %0d", in_ready, i); end
         end
         if (in_valid && in_ready) i++;
         if (out_valid === 1'b1) begin
            checks++; if ({cout, S} !== ve[r]) begin errors++; $display("FAIL b2b_result%0d: got %h expected %h", r, {cout, S}, ve[r]); end
            if (first < 0) first = cyc;
            last = cyc;
            r++;
         end
         step();
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (r != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", r); end
      checks++; if (last - first != 7) begin errors++; $display("FAIL b2b_contiguous: got span %0d expected 7", last - first); end
      step();
   endtask

   task automatic test_stall();
      int i = 0, r = 0, cyc = 0;
      logic [16:0] held = '0;
      while (r < 8 && cyc < 60) begin
         out_ready = !(cyc >= 4 && cyc < 7);
         in_valid = (i < 8);
         if (i < 8) begin A = va[i]; B = vb[i]; cin = vc[i]; sub = vs[i]; end
         #1;
         if (cyc >= 4 && cyc < 7) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0 at cycle %0d", in_ready, cyc); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid: got %b expected 1 at cycle %0d", out_valid, cyc); end
            if (cyc == 4) held = {cout, S};
            else begin
               checks++; if ({cout, S} !== held) begin errors++; $display("FAIL stall_hold: got %h expected %h", {cout, S}, held); end
            end
         end
         if (in_valid && in_ready) i++;
         if (out_valid === 1'b1 && out_ready) begin
            checks++; if ({cout, S} !== ve[r]) begin errors++; $display("FAIL stall_result%0d: got %h expected %h", r, {cout, S}, ve[r]); end
            r++;
         end
         step();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (r != 8) begin errors++; $display("FAIL stall_count: got %0d expected 8", r); end
      checks++; if (i != 8) begin errors++; $display("FAIL stall_accepted: got %0d expected 8", i); end
      step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         A = va[j]; B = vb[j]; cin = vc[j]; sub = vs[j]; in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
      checks++; if (S !== 16'h0000) begin errors++; $display("FAIL rstmid_S: got %h expected 0000", S); end
      for (int j = 0; j < 6; j++) begin
         step();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got out_valid=%b expected 0 at cycle %0d", out_valid, j); end
      end
   endtask

   initial begin
      step();
      test_reset();
      test_add_sub();
`ifdef PIPELINED_ADDER_FLAGS_EN
      test_flags();
`endif
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
